gdt_writer: RTL and testbench

- Write side of the Guest Deadline Table (GDT): owns the table storage and accepts per-guest deadline words from the hypervisor over a valid/ready handshake.
- Validates each word before committing it to the table.
- Defers any write that targets the currently running guest until the hypervisor switches guest.
- Provides a registered read port consumed by the deadline-checking logic.

---
 rtl/gdt_writer_if.sv | 27 ++
 rtl/gdt_writer.sv | 187 ++++++++++++++++++
 tb/tb_gdt_writer.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gdt_writer_if.sv
// Hypervisor-side configuration channel for the Guest Deadline Table writer.
// One deadline word per transfer, valid/ready handshake.
//   cfg_valid  : request valid (master -> slave)
//   cfg_ready  : slave can take a request (slave -> master)
//   cfg_guest  : target table row
//   cfg_column : 0 = temporal deadline, 1 = run-time deadline
//   cfg_data   : deadline value
interface gdt_writer_if #(
  parameter int GUEST_W = 3,
  parameter int DATA_W  = 32
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [GUEST_W-1:0] cfg_guest;
  logic               cfg_column;
  logic [DATA_W-1:0]  cfg_data;

  modport master (
    output cfg_valid, cfg_guest, cfg_column, cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_guest, cfg_column, cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/gdt_writer.sv
// Write side of the Guest Deadline Table. Owns the table storage, validates
// each incoming deadline word, defers writes aimed at the running guest until
// the hypervisor switches away from it, and offers a registered read port.
//
// Optional feature macro: GDT_WRITE_FORWARD_EN
//   defined   : a WRITE to the address being read forwards the new word to
//               rd_data in the same cycle (write-through)
//   undefined : read-before-write, rd_data returns the old word
//
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   cfg            : gdt_writer_if slave (cfg_valid/ready/guest/column/data)
//   current_guest  : guest currently executing
//   guest_active   : current_guest is meaningful
//   rd_guest       : read row
//   rd_column      : read column
//   rd_data        : registered read data, 1-cycle latency
//   entry_valid    : bit g set once both columns of row g were written
//   cfg_err        : one-cycle error pulse
//   cfg_err_code   : 01 zero, 10 run-time > temporal, 11 hold timeout (sticky)
//   busy           : FSM not idle
module gdt_writer #(
  parameter int NUM_GUESTS = 8,
  parameter int GUEST_W    = 3,
  parameter int DATA_W     = 32,
  parameter int HOLD_MAX   = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  gdt_writer_if.slave           cfg,
  input  logic [GUEST_W-1:0]    current_guest,
  input  logic                  guest_active,
  input  logic [GUEST_W-1:0]    rd_guest,
  input  logic                  rd_column,
  output logic [DATA_W-1:0]     rd_data,
  output logic [NUM_GUESTS-1:0] entry_valid,
  output logic                  cfg_err,
  output logic [1:0]            cfg_err_code,
  output logic                  busy
);

  localparam int HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, HOLD, WRITE} state_t;

  state_t              state;
  logic [GUEST_W-1:0]  req_guest;
  logic                req_column;
  logic [DATA_W-1:0]   req_data;
  logic [HOLD_W-1:0]   hold_cnt;

  logic [DATA_W-1:0]   tbl_temporal [NUM_GUESTS];
  logic [DATA_W-1:0]   tbl_runtime  [NUM_GUESTS];
  logic [NUM_GUESTS-1:0] vld_temporal;
  logic [NUM_GUESTS-1:0] vld_runtime;

  logic                req_in_range;
  logic                rd_in_range;
  logic [1:0]          req_err;
  logic                guest_running;
  logic                hold_done;
  logic [DATA_W-1:0]   rd_word;

  // Error code for a candidate word against the row contents as they stand
  // now: 00 ok, 01 zero value, 10 run-time deadline exceeds temporal.
  function automatic logic [1:0] validate(
    input logic [DATA_W-1:0] data,
    input logic              column,
    input logic [DATA_W-1:0] temporal,
    input logic              temporal_vld,
    input logic [DATA_W-1:0] runtime,
    input logic              runtime_vld
  );
    if (data == '0)                                 return 2'b01;
    if (column && temporal_vld && (data > temporal)) return 2'b10;
    if (!column && runtime_vld && (runtime > data))  return 2'b10;
    return 2'b00;
  endfunction

  assign cfg.cfg_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign entry_valid   = vld_temporal & vld_runtime;

  // Rows beyond NUM_GUESTS are reachable only when NUM_GUESTS < 2**GUEST_W.
  assign req_in_range  = (32'(req_guest) < NUM_GUESTS);
  assign rd_in_range   = (32'(rd_guest) < NUM_GUESTS);

  assign req_err = validate(req_data, req_column,
                            tbl_temporal[req_guest], vld_temporal[req_guest],
                            tbl_runtime[req_guest],  vld_runtime[req_guest]);

  assign guest_running = guest_active && (current_guest == req_guest);
  assign hold_done     = (hold_cnt == HOLD_W'(HOLD_MAX - 1));

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = rd_column ? tbl_runtime[rd_guest] : tbl_temporal[rd_guest];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      req_guest    <= '0;
      req_column   <= 1'b0;
      req_data     <= '0;
      hold_cnt     <= '0;
      cfg_err      <= 1'b0;
      cfg_err_code <= 2'b00;
      rd_data      <= '0;
      vld_temporal <= '0;
      vld_runtime  <= '0;
      for (int i = 0; i < NUM_GUESTS; i++) begin
        tbl_temporal[i] <= '0;
        tbl_runtime[i]  <= '0;
      end
    end else begin
      cfg_err <= 1'b0;

      // Read port samples the table before this cycle's write lands.
`ifdef GDT_WRITE_FORWARD_EN
      if ((state == WRITE) && (req_guest == rd_guest) && (req_column == rd_column)) begin
        rd_data <= req_data;
      end else begin
        rd_data <= rd_word;
      end
`else
      rd_data <= rd_word;
`endif

      case (state)
        IDLE: begin
          if (cfg.cfg_valid) begin
            req_guest  <= cfg.cfg_guest;
            req_column <= cfg.cfg_column;
            req_data   <= cfg.cfg_data;
            state      <= CHECK;
          end
        end

        CHECK: begin
          if (!req_in_range) begin
            state <= IDLE;                  // silently dropped
          end else if (req_err != 2'b00) begin
            cfg_err      <= 1'b1;
            cfg_err_code <= req_err;
            state        <= IDLE;
          end else if (guest_running) begin
            state <= HOLD;
          end else begin
            state <= WRITE;
          end
        end

        HOLD: begin
          // A guest switch wins over a timeout on the same cycle.
          if (!guest_running) begin
            hold_cnt <= '0;
            state    <= WRITE;
          end else if (hold_done) begin
            hold_cnt     <= '0;
            cfg_err      <= 1'b1;
            cfg_err_code <= 2'b11;
            state        <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        WRITE: begin
          if (req_column) begin
            tbl_runtime[req_guest]  <= req_data;
            vld_runtime[req_guest]  <= 1'b1;
          end else begin
            tbl_temporal[req_guest] <= req_data;
            vld_temporal[req_guest] <= 1'b1;
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gdt_writer.sv
// Self-checking bench for gdt_writer: directed scenarios plus a randomized
// run, all compared against a table-level reference model.
module tb_gdt_writer;

  localparam int NG = 8;
  localparam int GW = 3;
  localparam int DW = 32;
  localparam int HM = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [GW-1:0] current_guest;
  logic          guest_active;
  logic [GW-1:0] rd_guest;
  logic          rd_column;
  logic [DW-1:0] rd_data;
  logic [NG-1:0] entry_valid;
  logic          cfg_err;
  logic [1:0]    cfg_err_code;
  logic          busy;

  gdt_writer_if #(.GUEST_W(GW), .DATA_W(DW)) cfg_bus ();

  gdt_writer #(.NUM_GUESTS(NG), .GUEST_W(GW), .DATA_W(DW), .HOLD_MAX(HM)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg           (cfg_bus),
    .current_guest (current_guest),
    .guest_active  (guest_active),
    .rd_guest      (rd_guest),
    .rd_column     (rd_column),
    .rd_data       (rd_data),
    .entry_valid   (entry_valid),
    .cfg_err       (cfg_err),
    .cfg_err_code  (cfg_err_code),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc_count = 0;
  always @(posedge clk) cyc_count <= cyc_count + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the table as the hypervisor should see it.
  logic [DW-1:0] m_tbl [NG][2];
  bit            m_vld [NG][2];
  logic [1:0]    exp_code;

  function automatic void model_clear();
    for (int g = 0; g < NG; g++) begin
      for (int c = 0; c < 2; c++) begin
        m_tbl[g][c] = '0;
        m_vld[g][c] = 1'b0;
      end
    end
  endfunction

  function automatic logic [1:0] model_code(input int g, input int c, input logic [DW-1:0] d);
    if (d == 0) return 2'b01;
    if (c == 1 && m_vld[g][0] && d > m_tbl[g][0]) return 2'b10;
    if (c == 0 && m_vld[g][1] && m_tbl[g][1] > d) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_commit(input int g, input int c, input logic [DW-1:0] d);
    m_tbl[g][c] = d;
    m_vld[g][c] = 1'b1;
  endfunction

  function automatic logic [NG-1:0] model_ev();
    logic [NG-1:0] v;
    for (int g = 0; g < NG; g++) v[g] = m_vld[g][0] && m_vld[g][1];
    return v;
  endfunction

  // Stimulus helpers. They only flag an expired wait bound.
  task automatic send(input logic [GW-1:0] g, input logic c, input logic [DW-1:0] d);
    int budget;
    @(negedge clk);
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_guest  = g;
    cfg_bus.cfg_column = c;
    cfg_bus.cfg_data   = d;
    budget = 0;
    while (!cfg_bus.cfg_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!cfg_bus.cfg_ready) begin
      n_checks++;
      $display("FAIL send_timeout: cfg_ready=%0b required 1", cfg_bus.cfg_ready);
      cfg_bus.cfg_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 cfg_bus.cfg_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    @(negedge clk);
    while (busy && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (busy) begin
      n_checks++;
      $display("FAIL idle_timeout: busy=%0b required 0", busy);
    end
  endtask

  task automatic read_entry(input logic [GW-1:0] g, input logic c, output logic [DW-1:0] d);
    @(negedge clk);
    rd_guest  = g;
    rd_column = c;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_guest = '0; cfg_bus.cfg_column = 1'b0; cfg_bus.cfg_data = '0;
    current_guest = '0; guest_active = 1'b0; rd_guest = '0; rd_column = 1'b0;
    model_clear();
    exp_code = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cfg_bus.cfg_ready, busy, cfg_err, cfg_err_code} !== 5'b10000) begin
      $display("FAIL reset_ctrl: ready/busy/err/code=%b required 10000",
               {cfg_bus.cfg_ready, busy, cfg_err, cfg_err_code});
    end else n_pass++;
    n_checks++;
    if (entry_valid !== 8'h00 || rd_data !== 32'h0) begin
      $display("FAIL reset_data: entry_valid=%h rd_data=%h required 00/0", entry_valid, rd_data);
    end else n_pass++;
  endtask

  task automatic test_basic_write();
    logic [DW-1:0] d;
    guest_active = 1'b0;
    send(3'd2, 1'b0, 32'h1000);
    model_commit(2, 0, 32'h1000);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || cfg_bus.cfg_ready !== 1'b0) begin
      $display("FAIL basic_busy: busy=%0b ready=%0b required 1/0", busy, cfg_bus.cfg_ready);
    end else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || cfg_bus.cfg_ready !== 1'b1) begin
      $display("FAIL basic_idle: busy=%0b ready=%0b required 0/1", busy, cfg_bus.cfg_ready);
    end else n_pass++;

    send(3'd2, 1'b1, 32'h400);
    model_commit(2, 1, 32'h400);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (entry_valid !== 8'h00) begin
      $display("FAIL basic_early: entry_valid=%h required 00 one cycle after transfer", entry_valid);
    end else n_pass++;
    @(negedge clk);
    n_checks++;
    if (entry_valid !== model_ev()) begin
      $display("FAIL basic_entry: entry_valid=%h required %h", entry_valid, model_ev());
    end else n_pass++;
    read_entry(3'd2, 1'b1, d);
    n_checks++;
    if (d !== m_tbl[2][1]) begin
      $display("FAIL basic_read: rd_data=%h required %h", d, m_tbl[2][1]);
    end else n_pass++;
  endtask

  task automatic test_reject();
    logic [DW-1:0] d;
    logic [1:0]    code;
    code = model_code(2, 1, 32'h2000);
    send(3'd2, 1'b1, 32'h2000);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b1 || cfg_err_code !== code) begin
      $display("FAIL reject_order: err=%0b code=%b required 1/%b", cfg_err, cfg_err_code, code);
    end else n_pass++;
    exp_code = code;
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b0 || cfg_err_code !== exp_code) begin
      $display("FAIL reject_pulse: err=%0b code=%b required 0/%b", cfg_err, cfg_err_code, exp_code);
    end else n_pass++;
    read_entry(3'd2, 1'b1, d);
    n_checks++;
    if (d !== m_tbl[2][1] || entry_valid !== model_ev()) begin
      $display("FAIL reject_table: rd=%h ev=%h required %h/%h", d, entry_valid, m_tbl[2][1], model_ev());
    end else n_pass++;

    code = model_code(5, 0, 32'h0);
    send(3'd5, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b1 || cfg_err_code !== code) begin
      $display("FAIL reject_zero: err=%0b code=%b required 1/%b", cfg_err, cfg_err_code, code);
    end else n_pass++;
    exp_code = code;
    wait_idle();
  endtask

  task automatic test_hold_timeout();
    logic [DW-1:0] d;
    int bad;
    guest_active = 1'b1;
    current_guest = 3'd3;
    send(3'd3, 1'b0, 32'h500);
    @(negedge clk);                       // CHECK cycle
    bad = 0;
    for (int i = 1; i <= HM; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || cfg_bus.cfg_ready !== 1'b0 || cfg_err !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      $display("FAIL hold_wait: %0d bad cycles in hold, required 0", bad);
    end else n_pass++;
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b1 || cfg_err_code !== 2'b11 || busy !== 1'b0) begin
      $display("FAIL hold_timeout: err=%0b code=%b busy=%0b required 1/11/0", cfg_err, cfg_err_code, busy);
    end else n_pass++;
    exp_code = 2'b11;
    read_entry(3'd3, 1'b0, d);
    n_checks++;
    if (d !== m_tbl[3][0]) begin
      $display("FAIL hold_nowrite: rd=%h required %h", d, m_tbl[3][0]);
    end else n_pass++;
  endtask

  task automatic test_hold_release();
    logic [DW-1:0] d;
    int bad;
    guest_active = 1'b1;
    current_guest = 3'd3;
    send(3'd3, 1'b0, 32'h500);
    @(negedge clk);
    bad = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || cfg_bus.cfg_ready !== 1'b0) bad++;
    end
    current_guest = 3'd4;
    n_checks++;
    if (bad != 0) begin
      $display("FAIL release_hold: %0d bad cycles in hold, required 0", bad);
    end else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || cfg_err !== 1'b0) begin
      $display("FAIL release_done: busy=%0b err=%0b required 0/0", busy, cfg_err);
    end else n_pass++;
    model_commit(3, 0, 32'h500);
    read_entry(3'd3, 1'b0, d);
    n_checks++;
    if (d !== m_tbl[3][0]) begin
      $display("FAIL release_read: rd=%h required %h", d, m_tbl[3][0]);
    end else n_pass++;
  endtask

  task automatic test_reset_in_hold();
    logic [DW-1:0] d;
    guest_active = 1'b1;
    current_guest = 3'd3;
    send(3'd3, 1'b1, 32'h100);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({cfg_bus.cfg_ready, busy, cfg_err, cfg_err_code} !== 5'b10000 || entry_valid !== 8'h00 || rd_data !== 32'h0) begin
      $display("FAIL reset_async: ready/busy/err/code=%b ev=%h rd=%h required 10000/00/0",
               {cfg_bus.cfg_ready, busy, cfg_err, cfg_err_code}, entry_valid, rd_data);
    end else n_pass++;
    model_clear();
    exp_code = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    guest_active = 1'b0;
    read_entry(3'd3, 1'b0, d);
    n_checks++;
    if (d !== 32'h0) begin
      $display("FAIL reset_table: rd=%h required 0", d);
    end else n_pass++;
    send(3'd1, 1'b0, 32'h10);
    model_commit(1, 0, 32'h10);
    wait_idle();
    read_entry(3'd1, 1'b0, d);
    n_checks++;
    if (d !== m_tbl[1][0]) begin
      $display("FAIL reset_after: rd=%h required %h", d, m_tbl[1][0]);
    end else n_pass++;
  endtask

  task automatic test_read_collision();
    logic [DW-1:0] exp_same;
`ifdef GDT_WRITE_FORWARD_EN
    exp_same = 32'hABCD;
`else
    exp_same = m_tbl[1][0];
`endif
    rd_guest  = 3'd1;
    rd_column = 1'b0;
    send(3'd1, 1'b0, 32'hABCD);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (rd_data !== exp_same) begin
      $display("FAIL collide_same: rd=%h required %h", rd_data, exp_same);
    end else n_pass++;
    model_commit(1, 0, 32'hABCD);
    @(negedge clk);
    n_checks++;
    if (rd_data !== m_tbl[1][0]) begin
      $display("FAIL collide_next: rd=%h required %h", rd_data, m_tbl[1][0]);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [GW-1:0] rg [4] = '{3'd4, 3'd4, 3'd6, 3'd6};
    logic          rc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [DW-1:0] rdv [4] = '{32'h800, 32'h200, 32'h900, 32'h900};
    int t [4];
    int idx, budget;
    logic [DW-1:0] d;
    guest_active = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (model_code(rg[i], rc[i], rdv[i]) == 2'b00) model_commit(rg[i], rc[i], rdv[i]);
    end
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_guest = rg[0]; cfg_bus.cfg_column = rc[0]; cfg_bus.cfg_data = rdv[0];
    idx = 0;
    budget = 0;
    while (idx < 4 && budget < 200) begin
      if (cfg_bus.cfg_ready) begin
        @(posedge clk);
        #1;
        t[idx] = cyc_count;
        idx++;
        if (idx < 4) begin
          cfg_bus.cfg_guest = rg[idx]; cfg_bus.cfg_column = rc[idx]; cfg_bus.cfg_data = rdv[idx];
        end else cfg_bus.cfg_valid = 1'b0;
      end
      @(negedge clk);
      budget++;
    end
    cfg_bus.cfg_valid = 1'b0;
    n_checks++;
    if (idx != 4) begin
      $display("FAIL b2b_count: transfers=%0d required 4", idx);
    end else n_pass++;
    for (int i = 1; i < idx; i++) begin
      n_checks++;
      if (t[i] - t[i-1] != 3) begin
        $display("FAIL b2b_spacing: gap=%0d required 3", t[i] - t[i-1]);
      end else n_pass++;
    end
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      read_entry(rg[i], rc[i], d);
      n_checks++;
      if (d !== m_tbl[rg[i]][rc[i]]) begin
        $display("FAIL b2b_read: rd=%h required %h", d, m_tbl[rg[i]][rc[i]]);
      end else n_pass++;
    end
    n_checks++;
    if (entry_valid !== model_ev()) begin
      $display("FAIL b2b_entry: ev=%h required %h", entry_valid, model_ev());
    end else n_pass++;
  endtask

  task automatic test_random();
    logic [GW-1:0] g;
    logic          c;
    logic [DW-1:0] d;
    logic [DW-1:0] r;
    logic [1:0]    code;
    for (int n = 0; n < 40; n++) begin
      g = GW'($urandom_range(0, NG-1));
      c = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 5) == 0) ? 32'h0 : 32'($urandom_range(1, 32'h3000));
      guest_active  = 1'($urandom_range(0, 1));
      current_guest = GW'(g + 1 + $urandom_range(0, 6));
      code = model_code(g, c, d);
      send(g, c, d);
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (cfg_err !== (code != 2'b00) || cfg_err_code !== ((code != 2'b00) ? code : exp_code)) begin
        $display("FAIL rand_err: g=%0d c=%0d d=%h err=%0b code=%b required %0b/%b", g, c, d,
                 cfg_err, cfg_err_code, (code != 2'b00), (code != 2'b00) ? code : exp_code);
      end else n_pass++;
      if (code != 2'b00) exp_code = code;
      else model_commit(g, c, d);
      wait_idle();
      read_entry(g, c, r);
      n_checks++;
      if (r !== m_tbl[g][c] || entry_valid !== model_ev()) begin
        $display("FAIL rand_table: g=%0d c=%0d rd=%h ev=%h required %h/%h", g, c, r, entry_valid,
                 m_tbl[g][c], model_ev());
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_reject();
    test_hold_timeout();
    test_hold_release();
    test_reset_in_hold();
    test_read_collision();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
